// File: rtl/sram_group_cmd_sched_if.sv
// Request/command bundle between requesters, the scheduler and the west command lanes.
// Latency: none, wires only.
// Backpressure: req_rdy grants toward requesters; command lanes carry no ready.
interface sram_group_cmd_sched_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_LANE = 8,
    parameter int NUM_BANK = 16,
    parameter int BANK_W   = 4,
    parameter int LANE_W   = 3,
    parameter int PLD_W    = 64
);
    logic [NUM_REQ-1:0]          req_vld;
    logic [NUM_REQ-1:0]          req_rdy;
    logic [NUM_REQ-1:0]          req_is_wr;
    logic [NUM_REQ*BANK_W-1:0]   req_bank;
    logic [NUM_REQ*LANE_W-1:0]   req_lane;
    logic [NUM_REQ*PLD_W-1:0]    req_pld;
    logic [NUM_LANE-1:0]         rd_cmd_vld;
    logic [NUM_LANE*PLD_W-1:0]   rd_cmd_pld;
    logic [NUM_LANE-1:0]         wr_cmd_vld;
    logic [NUM_LANE*PLD_W-1:0]   wr_cmd_pld;
    logic [NUM_BANK-1:0]         bank_busy;

    // Requester/mesh side.
    modport master (
        output req_vld, req_is_wr, req_bank, req_lane, req_pld,
        input  req_rdy, rd_cmd_vld, rd_cmd_pld, wr_cmd_vld, wr_cmd_pld, bank_busy
    );

    // Scheduler side.
    modport slave (
        input  req_vld, req_is_wr, req_bank, req_lane, req_pld,
        output req_rdy, rd_cmd_vld, rd_cmd_pld, wr_cmd_vld, wr_cmd_pld, bank_busy
    );
endinterface

// File: rtl/sram_group_cmd_sched.sv
// Round-robin read/write command scheduler with per-bank busy windows for the 4x4 SRAM mesh.
// Latency: grant in cycle t (combinational req_rdy), one-cycle command pulse on its lane in t+1.
// Backpressure: requesters wait on req_rdy (bank busy or lost arbitration); the mesh never stalls.
// Optional: define SRAM_GROUP_SCHED_AGE_EN to let requesters aged >= AGE_MAX pre-empt round-robin.
module sram_group_cmd_sched #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_LANE = 8,
    parameter int NUM_BANK = 16,
    parameter int BANK_W   = 4,
    parameter int LANE_W   = 3,
    parameter int PLD_W    = 64,
    parameter int BUSY_CYC = 2,
    parameter int AGE_MAX  = 15
) (
    input logic                   clk,
    input logic                   rst_n,
    sram_group_cmd_sched_if.slave bus
);
    localparam int REQ_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BANK_SPAN = 1 << BANK_W;

    // Counters are 4 bits wide and the bank index must cover every tracked bank.
    if (BUSY_CYC < 1 || BUSY_CYC > 15 || AGE_MAX < 1 || AGE_MAX > 15 ||
        NUM_BANK > BANK_SPAN || NUM_LANE > (1 << LANE_W)) begin : g_param_check
        $error("sram_group_cmd_sched: parameter out of range");
    end

    typedef struct packed {
        logic              is_wr;
        logic [LANE_W-1:0] lane;
        logic [BANK_W-1:0] bank;
        logic [PLD_W-1:0]  pld;
    } cmd_t;

    logic [REQ_W-1:0]          rr_ptr;
    logic [3:0]                busy_cnt [NUM_BANK];
    logic [BANK_SPAN-1:0]      busy_ext;
    logic [NUM_REQ-1:0]        elig;
    cmd_t                      req_cmd [NUM_REQ];
    logic                      grant_vld;
    logic [REQ_W-1:0]          grant_idx;
    logic [NUM_REQ-1:0]        grant_oh;
    cmd_t                      grant_cmd;
    logic [NUM_LANE-1:0]       rd_vld_q;
    logic [NUM_LANE-1:0]       wr_vld_q;
    logic [NUM_LANE*PLD_W-1:0] rd_pld_q;
    logic [NUM_LANE*PLD_W-1:0] wr_pld_q;

    // Unpack the flattened request buses and decide who may be granted this cycle.
    always_comb begin
        busy_ext = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            busy_ext[b] = (busy_cnt[b] != 4'd0);
        end
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cmd[i].is_wr = bus.req_is_wr[i];
            req_cmd[i].lane  = bus.req_lane[i*LANE_W +: LANE_W];
            req_cmd[i].bank  = bus.req_bank[i*BANK_W +: BANK_W];
            req_cmd[i].pld   = bus.req_pld[i*PLD_W +: PLD_W];
            // Out-of-range targets are never eligible; a busy bank blocks until its window expires.
            elig[i] = bus.req_vld[i]
                   && (int'(req_cmd[i].bank) < NUM_BANK)
                   && (int'(req_cmd[i].lane) < NUM_LANE)
                   && !busy_ext[req_cmd[i].bank];
        end
    end

`ifdef SRAM_GROUP_SCHED_AGE_EN
    logic [3:0]         age_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] aged;

    // A requester is "aged" once it has waited AGE_MAX cycles and is eligible now.
    always_comb begin
        aged = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aged[i] = elig[i] && (int'(age_cnt[i]) >= AGE_MAX);
        end
    end

    // Age counts consecutive waiting cycles; any grant or a dropped request restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                age_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_vld[i] || grant_oh[i]) begin
                    age_cnt[i] <= '0;
                end else if (age_cnt[i] != 4'hF) begin
                    age_cnt[i] <= age_cnt[i] + 4'd1;
                end
            end
        end
    end
`endif

    // Pick the first eligible requester at or after rr_ptr, wrapping; aged requesters win outright.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = REQ_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
`ifdef SRAM_GROUP_SCHED_AGE_EN
        // Descending scan so the lowest aged index is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (aged[i]) begin
                grant_vld = 1'b1;
                grant_idx = REQ_W'(i);
            end
        end
`endif
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
        grant_cmd = req_cmd[grant_idx];
    end

    // No grant may be visible while reset is held, even though eligibility is combinational.
    assign bus.req_rdy = rst_n ? grant_oh : '0;

    // The pointer moves just past the winner and holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Busy window per bank: load on issue, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                busy_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (grant_vld && int'(grant_cmd.bank) == b) begin
                    busy_cnt[b] <= 4'(BUSY_CYC);
                end else if (busy_cnt[b] != 4'd0) begin
                    busy_cnt[b] <= busy_cnt[b] - 4'd1;
                end
            end
        end
    end

    assign bus.bank_busy = busy_ext[NUM_BANK-1:0];

    // Output stage: single-cycle valid on the granted lane; payloads of idle lanes hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            wr_vld_q <= '0;
            rd_pld_q <= '0;
            wr_pld_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LANE; l++) begin
                rd_vld_q[l] <= grant_vld && !grant_cmd.is_wr && (int'(grant_cmd.lane) == l);
                wr_vld_q[l] <= grant_vld &&  grant_cmd.is_wr && (int'(grant_cmd.lane) == l);
                if (grant_vld && !grant_cmd.is_wr && (int'(grant_cmd.lane) == l)) begin
                    rd_pld_q[l*PLD_W +: PLD_W] <= grant_cmd.pld;
                end
                if (grant_vld && grant_cmd.is_wr && (int'(grant_cmd.lane) == l)) begin
                    wr_pld_q[l*PLD_W +: PLD_W] <= grant_cmd.pld;
                end
            end
        end
    end

    assign bus.rd_cmd_vld = rd_vld_q;
    assign bus.wr_cmd_vld = wr_vld_q;
    assign bus.rd_cmd_pld = rd_pld_q;
    assign bus.wr_cmd_pld = wr_pld_q;

endmodule

// File: tb/tb_sram_group_cmd_sched.sv
// Directed bench for sram_group_cmd_sched: default instance plus a narrow one (6 lanes, 12 banks).
// Latency: checks grant in cycle t and the lane pulse in t+1.
// Backpressure: requesters hold their request until req_rdy is seen.
module tb_sram_group_cmd_sched;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    sram_group_cmd_sched_if #(.NUM_LANE(8), .NUM_BANK(16)) bus ();
    sram_group_cmd_sched_if #(.NUM_LANE(6), .NUM_BANK(12)) bus_s ();

    sram_group_cmd_sched #(.NUM_LANE(8), .NUM_BANK(16), .BUSY_CYC(2), .AGE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sram_group_cmd_sched #(.NUM_LANE(6), .NUM_BANK(12), .BUSY_CYC(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input int bank, input int lane, input logic [63:0] pld);
        bus.req_vld[i]         = 1'b1;
        bus.req_is_wr[i]       = wr;
        bus.req_bank[i*4 +: 4] = bank[3:0];
        bus.req_lane[i*3 +: 3] = lane[2:0];
        bus.req_pld[i*64 +: 64] = pld;
    endtask

    task automatic clr(input int i);
        bus.req_vld[i] = 1'b0;
    endtask

    task automatic set_req_s(input int i, input bit wr, input int bank, input int lane, input logic [63:0] pld);
        bus_s.req_vld[i]          = 1'b1;
        bus_s.req_is_wr[i]        = wr;
        bus_s.req_bank[i*4 +: 4]  = bank[3:0];
        bus_s.req_lane[i*3 +: 3]  = lane[2:0];
        bus_s.req_pld[i*64 +: 64] = pld;
    endtask

    task automatic clr_s(input int i);
        bus_s.req_vld[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [3:0] seen;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.req_vld = '0;   bus.req_is_wr = '0;   bus.req_bank = '0;   bus.req_lane = '0;   bus.req_pld = '0;
        bus_s.req_vld = '0; bus_s.req_is_wr = '0; bus_s.req_bank = '0; bus_s.req_lane = '0; bus_s.req_pld = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: a valid request must not be granted while rst_n is low.
        set_req(0, 1'b0, 3, 2, 64'hA5);
        #1;
        chk("rst_rdy",    bus.req_rdy, 0);
        chk("rst_rd_vld", bus.rd_cmd_vld, 0);
        chk("rst_wr_vld", bus.wr_cmd_vld, 0);
        chk("rst_busy",   bus.bank_busy, 0);
        chk("rst_rd_pld", bus.rd_cmd_pld[2*64 +: 64], 0);
        clr(0);
        tick();
        rst_n = 1'b1;
        tick();

        // Round-robin: four reads to banks 0..3, lanes 0..3, one grant per cycle.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, i, i, 64'h1000 + 64'(i));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_rdy%0d", k), bus.req_rdy, 64'h1 << k);
            tick();
            clr(k);
            chk($sformatf("rr_rd_vld%0d", k), bus.rd_cmd_vld, 64'h1 << k);
            chk($sformatf("rr_rd_pld%0d", k), bus.rd_cmd_pld[k*64 +: 64], 64'h1000 + 64'(k));
        end

        // Re-request as writes on lanes 4..7: order restarts at req0.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, i, 4 + i, 64'h2000 + 64'(i));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr2_rdy%0d", k), bus.req_rdy, 64'h1 << k);
            tick();
            clr(k);
            chk($sformatf("rr2_wr_vld%0d", k), bus.wr_cmd_vld, 64'h1 << (4 + k));
            chk($sformatf("rr2_rd_vld%0d", k), bus.rd_cmd_vld, 0);
            chk($sformatf("rr2_wr_pld%0d", k), bus.wr_cmd_pld[(4+k)*64 +: 64], 64'h2000 + 64'(k));
        end
        chk("rr2_rd_pld_hold", bus.rd_cmd_pld[3*64 +: 64], 64'h1003);
        repeat (3) tick();

        // Bank conflict: req0 and req1 both write bank 5; req1 waits BUSY_CYC cycles.
        set_req(0, 1'b1, 5, 1, 64'hC0);
        set_req(1, 1'b1, 5, 3, 64'hC1);
        #1;
        chk("cf_rdy_t", bus.req_rdy, 4'b0001);
        tick();
        clr(0);
        #1;
        chk("cf_rdy_t1",  bus.req_rdy, 0);
        chk("cf_busy_t1", bus.bank_busy, 16'h0020);
        chk("cf_wr_vld_t1", bus.wr_cmd_vld, 8'h02);
        chk("cf_wr_pld_t1", bus.wr_cmd_pld[1*64 +: 64], 64'hC0);
        tick();
        #1;
        chk("cf_rdy_t2",  bus.req_rdy, 0);
        chk("cf_busy_t2", bus.bank_busy, 16'h0020);
        chk("cf_wr_vld_t2", bus.wr_cmd_vld, 0);
        tick();
        #1;
        chk("cf_rdy_t3",  bus.req_rdy, 4'b0010);
        chk("cf_busy_t3", bus.bank_busy, 0);
        tick();
        clr(1);
        chk("cf_wr_vld_t4", bus.wr_cmd_vld, 8'h08);
        chk("cf_wr_pld_t4", bus.wr_cmd_pld[3*64 +: 64], 64'hC1);
        chk("cf_busy_t4", bus.bank_busy, 16'h0020);
        tick();

        // Wrap: grant req2 to move rr_ptr to 3, then req0 and req3 compete.
        set_req(2, 1'b0, 8, 0, 64'h20);
        #1;
        chk("wrap_rdy2", bus.req_rdy, 4'b0100);
        tick();
        clr(2);
        set_req(0, 1'b0, 9, 1, 64'h30);
        set_req(3, 1'b0, 10, 2, 64'h33);
        #1;
        chk("wrap_rdy3", bus.req_rdy, 4'b1000);
        tick();
        set_req(3, 1'b0, 11, 2, 64'h34);
        #1;
        chk("wrap_rdy0", bus.req_rdy, 4'b0001);
        chk("wrap_pld3", bus.rd_cmd_pld[2*64 +: 64], 64'h33);
        tick();
        clr(0);
        #1;
        chk("wrap_rdy3b", bus.req_rdy, 4'b1000);
        chk("wrap_pld0", bus.rd_cmd_pld[1*64 +: 64], 64'h30);
        tick();
        clr(3);
        chk("wrap_pld3b", bus.rd_cmd_pld[2*64 +: 64], 64'h34);
        chk("wrap_vld3b", bus.rd_cmd_vld, 8'h04);
        tick();

        // Invalid targets on the narrow instance: lane 6 and bank 12 never granted.
        set_req_s(0, 1'b0, 0, 6, 64'h66);
        set_req_s(1, 1'b0, 12, 0, 64'h67);
        set_req_s(2, 1'b0, 1, 1, 64'h77);
        #1;
        chk("inv_rdy_req2", bus_s.req_rdy, 4'b0100);
        tick();
        clr_s(2);
        chk("inv_vld_req2", bus_s.rd_cmd_vld, 6'b000010);
        set_req_s(3, 1'b1, 11, 5, 64'h55);
        #1;
        chk("inv_rdy_req3", bus_s.req_rdy, 4'b1000);
        tick();
        clr_s(3);
        chk("inv_vld_req3", bus_s.wr_cmd_vld, 6'b100000);
        chk("inv_pld_req3", bus_s.wr_cmd_pld[5*64 +: 64], 64'h55);
        seen = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            seen = seen | bus_s.req_rdy;
            tick();
        end
        chk("inv_never_rdy", seen, 0);
        clr_s(0);
        clr_s(1);

        // Reset mid-burst: outputs clear immediately and no pulse follows.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, i, i, 64'h4000 + 64'(i));
        #1;
        chk("mid_rdy", bus.req_rdy, 4'b0001);
        tick();
        clr(0);
        chk("mid_vld_pre", bus.rd_cmd_vld, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",  bus.rd_cmd_vld, 0);
        chk("mid_rst_pld",  bus.rd_cmd_pld[0 +: 64], 0);
        chk("mid_rst_busy", bus.bank_busy, 0);
        chk("mid_rst_rdy",  bus.req_rdy, 0);
        for (int i = 0; i < 4; i++) clr(i);
        tick();
        tick();
        chk("mid_rst_rd_hold", bus.rd_cmd_vld, 0);
        chk("mid_rst_wr_hold", bus.wr_cmd_vld, 0);
        rst_n = 1'b1;
        set_req(0, 1'b0, 3, 2, 64'hA5);
        #1;
        chk("post_rdy", bus.req_rdy, 4'b0001);
        tick();
        clr(0);
        chk("post_rd_vld", bus.rd_cmd_vld, 8'h04);
        chk("post_rd_pld", bus.rd_cmd_pld[2*64 +: 64], 64'hA5);
        chk("post_busy",   bus.bank_busy, 16'h0008);
        tick();
        chk("post_rd_vld_drop", bus.rd_cmd_vld, 0);
        chk("post_rd_pld_hold", bus.rd_cmd_pld[2*64 +: 64], 64'hA5);
        chk("post_busy2",  bus.bank_busy, 16'h0008);
        tick();
        chk("post_busy3",  bus.bank_busy, 0);

`ifdef SRAM_GROUP_SCHED_AGE_EN
        // Aging: req2 on a free bank while req0/req1/req3 keep requesting; req2 wins within 5 cycles.
        begin
            bit got2;
            got2 = 1'b0;
            set_req(0, 1'b0, 13, 0, 64'hE0);
            set_req(1, 1'b0, 14, 1, 64'hE1);
            set_req(3, 1'b0, 15, 3, 64'hE3);
            set_req(2, 1'b0, 12, 2, 64'hE2);
            for (int c = 0; c < 5 && !got2; c++) begin
                #1;
                if (bus.req_rdy[2]) got2 = 1'b1;
                tick();
            end
            chk("age_grant_req2", got2, 1'b1);
            for (int i = 0; i < 4; i++) clr(i);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
